// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch types and defaults
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  localparam int PC_STEP = 4;
  typedef enum logic [1:0] {S_RESET, S_REQ, S_WAIT, S_DRAIN} fetch_state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO of fetch entries with flush
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic [AW:0]  o_count,
  output logic         o_full,
  output logic         o_empty
);
  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr <= r_wr + AW'(1);
      end
      if (i_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end
  assign o_head = r_mem[r_rd];
  assign o_count = r_count;
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: owns the PC, issues single-outstanding imem requests,
// buffers responses for decode and discards stale responses after redirects
module fetch_controller #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc
);
  import riscv_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t r_state, w_next;
  logic [XLEN-1:0] r_pc, r_req_pc;
  fetch_entry_t w_head, w_entry;
  logic [CW-1:0] w_count;
  logic w_full, w_empty, w_hs, w_rsp, w_redir, w_pop, w_push;
  assign w_redir = redirect_valid && r_state != S_RESET;
  assign imem_req_valid = r_state == S_REQ && w_count < CW'(FIFO_DEPTH);
  assign imem_req_addr = r_pc;
  assign w_hs = imem_req_valid && imem_req_ready;
  // responses outside WAIT/DRAIN violate the protocol and are ignored
  assign w_rsp = imem_rsp_valid && (r_state == S_WAIT || r_state == S_DRAIN);
  assign w_push = r_state == S_WAIT && w_rsp && !w_full;
  assign w_entry = '{pc: r_req_pc, instr: imem_rsp_data};
  assign if_valid = !w_empty && !redirect_valid;
  assign w_pop = if_valid && if_ready;
  assign if_instr = w_head.instr;
  assign if_pc = w_head.pc;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET: w_next = S_REQ;
      S_REQ:   w_next = w_hs ? (w_redir ? S_DRAIN : S_WAIT) : S_REQ;
      default: w_next = w_rsp ? S_REQ : (w_redir ? S_DRAIN : r_state);
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RESET;
      r_pc <= RESET_PC;
      r_req_pc <= '0;
    end else begin
      r_state <= w_next;
      r_pc <= w_redir ? redirect_pc : w_hs ? r_pc + XLEN'(PC_STEP) : r_pc;
      if (w_hs) r_req_pc <= r_pc;
    end
  end
  fetch_buffer #(.DEPTH(FIFO_DEPTH)) u_buf (
    .clk(clk),
    .rst_n(rst),
    .i_push(w_push),
    .i_data(w_entry),
    .i_pop(w_pop),
    .i_flush(w_redir),
    .o_head(w_head),
    .o_count(w_count),
    .o_full(w_full),
    .o_empty(w_empty)
  );
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed scenarios for fetch_controller with a behavioural imem
module tb_fetch_controller;
  logic clk = 0, rst_n = 1;
  logic req_ready = 1, rsp_valid = 0, redir = 0, if_ready = 1;
  logic [31:0] rsp_data = 0, redir_pc = 0;
  logic req_valid, if_valid;
  logic [31:0] req_addr, if_instr, if_pc;
  logic req_valid2, rsp_valid2 = 0, if_valid2;
  logic [31:0] req_addr2, if_instr2, if_pc2;
  int errors = 0, checks = 0, cyc = 0, rel = 0;
  int m_cnt = 0, m_lat = 1;
  bit m_poison = 0, pend2 = 0, seen_bad = 0, ok;
  logic [31:0] m_data = 0;
  logic [63:0] pops[$];
  int pop_cyc[$];
  logic [31:0] reqs[$], reqs2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fetch_controller dut (
    .clk(clk), .rst(rst_n),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redir), .redirect_pc(redir_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );

  fetch_controller #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst_n),
    .imem_req_valid(req_valid2), .imem_req_ready(1'b1), .imem_req_addr(req_addr2),
    .imem_rsp_valid(rsp_valid2), .imem_rsp_data(32'h0000_0013),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .if_valid(if_valid2), .if_ready(1'b1), .if_instr(if_instr2), .if_pc(if_pc2)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // memory: answers each accepted request m_lat cycles later
  initial forever begin
    @(negedge clk);
    #1;
    rsp_valid = 0;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        rsp_valid = 1;
        rsp_data = m_data;
      end
    end
    if (rst_n && req_valid && req_ready) begin
      m_cnt = m_lat;
      m_data = m_poison ? 32'hDEADBEEF : instr_of(req_addr);
      m_poison = 0;
    end
    rsp_valid2 = pend2;
    pend2 = rst_n && req_valid2;
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (if_valid && if_ready) begin
        pops.push_back({if_pc, if_instr});
        pop_cyc.push_back(cyc);
      end
      if (req_valid && req_ready) reqs.push_back(req_addr);
      if (req_valid2) reqs2.push_back(req_addr2);
      if (if_valid && if_instr == 32'hDEADBEEF) seen_bad = 1;
    end
  end

  task automatic do_reset();
    rst_n = 0;
    redir = 0;
    if_ready = 1;
    m_lat = 1;
    m_poison = 0;
    repeat (2) @(negedge clk);
    m_cnt = 0;
    pops.delete();
    pop_cyc.delete();
    reqs.delete();
    reqs2.delete();
    seen_bad = 0;
    rel = cyc;
    rst_n = 1;
  endtask

  task automatic wait_pops(input int n, output bit done);
    for (int i = 0; i < 80 && pops.size() < n; i++) begin
      @(negedge clk);
      #3;
    end
    done = pops.size() >= n;
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b want 0", req_valid); end
    checks++; if (req_addr !== 32'h0) begin errors++; $display("FAIL rst_req_addr got %h want 0", req_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid got %b want 0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_if_instr got %h want 0", if_instr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_if_pc got %h want 0", if_pc); end
    checks++; if (req_addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rst_req_addr2 got %h want fffffffc", req_addr2); end
    do_reset();
    #2;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL cycle1_req_valid got %b want 0", req_valid); end
    @(negedge clk);
    #2;
    checks++; if ({req_valid, req_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL cycle2_req got %b/%h want 1/0", req_valid, req_addr); end
  endtask

  task automatic test_stream();
    wait_pops(4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stream_timeout got %0d pops want 4", pops.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pops[i] !== {32'(4 * i), instr_of(32'(4 * i))}) begin
        errors++; $display("FAIL stream_pop%0d got %h want %h", i, pops[i], {32'(4 * i), instr_of(32'(4 * i))});
      end
    end
    checks++; if (pop_cyc[0] - rel != 3) begin errors++; $display("FAIL stream_first_latency got %0d want 3", pop_cyc[0] - rel); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (pop_cyc[i] - pop_cyc[i-1] != 2) begin errors++; $display("FAIL stream_spacing%0d got %0d want 2", i, pop_cyc[i] - pop_cyc[i-1]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    if_ready = 0;
    repeat (12) @(negedge clk);
    #3;
    checks++; if (reqs.size() != 2) begin errors++; $display("FAIL bp_req_count got %0d want 2", reqs.size()); end
    checks++; if ({reqs[0], reqs[1]} !== {32'h0, 32'h4}) begin errors++; $display("FAIL bp_req_addrs got %h want 0/4", {reqs[0], reqs[1]}); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid got %b want 0", req_valid); end
    checks++; if ({if_valid, if_pc} !== {1'b1, 32'h0}) begin errors++; $display("FAIL bp_head got %b/%h want 1/0", if_valid, if_pc); end
    @(negedge clk);
    if_ready = 1;
    wait_pops(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got %0d pops want 3", pops.size()); end
    checks++; if ({pops[0][63:32], pops[1][63:32], pops[2][63:32]} !== {32'h0, 32'h4, 32'h8}) begin
      errors++; $display("FAIL bp_pop_order got %h %h %h want 0 4 8", pops[0][63:32], pops[1][63:32], pops[2][63:32]);
    end
    checks++; if (reqs[2] !== 32'h8) begin errors++; $display("FAIL bp_resume_addr got %h want 8", reqs[2]); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    m_lat = 3;
    m_poison = 1;
    @(negedge clk);
    #3;
    m_lat = 1;
    checks++; if (reqs.size() != 1) begin errors++; $display("FAIL rw_first_req got %0d want 1", reqs.size()); end
    @(negedge clk);
    redir = 1;
    redir_pc = 32'h100;
    #3;
    checks++; if ({if_valid, req_valid} !== 2'b00) begin errors++; $display("FAIL rw_in_wait got %b want 00", {if_valid, req_valid}); end
    @(negedge clk);
    redir = 0;
    #3;
    checks++; if ({req_valid, req_addr} !== {1'b0, 32'h100}) begin errors++; $display("FAIL rw_drain got %b/%h want 0/100", req_valid, req_addr); end
    @(negedge clk);
    #3;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rw_drain2 got %b want 0", req_valid); end
    @(negedge clk);
    #3;
    checks++; if ({req_valid, req_addr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL rw_new_req got %b/%h want 1/100", req_valid, req_addr); end
    wait_pops(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rw_timeout got %0d pops want 2", pops.size()); end
    checks++; if (pops[0] !== {32'h100, instr_of(32'h100)}) begin errors++; $display("FAIL rw_pop0 got %h want %h", pops[0], {32'h100, instr_of(32'h100)}); end
    checks++; if (pops[1][63:32] !== 32'h104) begin errors++; $display("FAIL rw_pop1 got %h want 104", pops[1][63:32]); end
    checks++; if (seen_bad !== 1'b0) begin errors++; $display("FAIL rw_stale_seen got %b want 0", seen_bad); end
  endtask

  task automatic test_redirect_rsp();
    do_reset();
    repeat (2) @(negedge clk);
    redir = 1;
    redir_pc = 32'h200;
    @(negedge clk);
    redir_pc = 32'h300;
    #3;
    checks++; if ({req_valid, req_addr} !== {1'b1, 32'h200}) begin errors++; $display("FAIL rr_req200 got %b/%h want 1/200", req_valid, req_addr); end
    @(negedge clk);
    redir = 0;
    #3;
    checks++; if ({req_valid, req_addr} !== {1'b0, 32'h300}) begin errors++; $display("FAIL rr_drain got %b/%h want 0/300", req_valid, req_addr); end
    @(negedge clk);
    #3;
    checks++; if ({req_valid, req_addr} !== {1'b1, 32'h300}) begin errors++; $display("FAIL rr_req300 got %b/%h want 1/300", req_valid, req_addr); end
    wait_pops(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_timeout got %0d pops want 1", pops.size()); end
    checks++; if (pops[0] !== {32'h300, instr_of(32'h300)}) begin errors++; $display("FAIL rr_pop0 got %h want %h", pops[0], {32'h300, instr_of(32'h300)}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    if_ready = 0;
    repeat (4) @(negedge clk);
    #3;
    checks++; if ({if_valid, req_valid} !== 2'b10) begin errors++; $display("FAIL rm_before got %b want 10", {if_valid, req_valid}); end
    rst_n = 0;
    #1;
    checks++; if ({if_valid, req_valid} !== 2'b00) begin errors++; $display("FAIL rm_valids got %b want 00", {if_valid, req_valid}); end
    checks++; if ({req_addr, if_pc, if_instr} !== 96'h0) begin errors++; $display("FAIL rm_values got %h want 0", {req_addr, if_pc, if_instr}); end
    do_reset();
    wait_pops(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_timeout got %0d pops want 1", pops.size()); end
    checks++; if ({reqs[0], pops[0]} !== {32'h0, 32'h0, instr_of(32'h0)}) begin errors++; $display("FAIL rm_restart got %h want %h", {reqs[0], pops[0]}, {32'h0, 32'h0, instr_of(32'h0)}); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 40 && reqs2.size() < 2; i++) begin
      @(negedge clk);
      #3;
    end
    checks++; if (reqs2.size() < 2) begin errors++; $display("FAIL wrap_timeout got %0d reqs want 2", reqs2.size()); end
    checks++; if ({reqs2[0], reqs2[1]} !== {32'hFFFF_FFFC, 32'h0}) begin errors++; $display("FAIL wrap_addrs got %h want fffffffc00000000", {reqs2[0], reqs2[1]}); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rsp();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end
endmodule
